// File: rtl/fifo_rd_deframer_pkg.sv
// ============================================================================
// fifo_deframer_pkg : shared types and header field helpers for the deframer
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_deframer_pkg;

  typedef enum logic [0:0] {
    HDR  = 1'b0,
    DATA = 1'b1
  } state_e;

  localparam int HDR_LEN_LSB = 0;

  // The ID field sits directly above the length field.
  function automatic int hdr_id_lsb(input int len_size);
    return HDR_LEN_LSB + len_size;
  endfunction

  function automatic logic [31:0] hdr_len(input logic [63:0] hdr, input int len_size);
    logic [63:0] mask;
    mask = (64'd1 << len_size) - 64'd1;
    return 32'((hdr >> HDR_LEN_LSB) & mask);
  endfunction

  function automatic logic [31:0] hdr_id(input logic [63:0] hdr, input int len_size,
                                         input int id_size);
    logic [63:0] mask;
    mask = (64'd1 << id_size) - 64'd1;
    return 32'((hdr >> hdr_id_lsb(len_size)) & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_deframer_if.sv
// ============================================================================
// fifo_rd_deframer_if : FIFO read port plus payload stream of the deframer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fifo_rd_deframer_if #(
  parameter int DATA_SIZE = 32,
  parameter int ID_SIZE   = 4
);
  logic                 rempty;
  logic [DATA_SIZE-1:0] rdata;
  logic                 rpop;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out_data;
  logic [ID_SIZE-1:0]   out_id;
  logic                 out_last;
  logic                 busy;

  modport master (
    input  rempty, rdata, out_ready,
    output rpop, out_valid, out_data, out_id, out_last, busy
  );

  modport slave (
    output rempty, rdata, out_ready,
    input  rpop, out_valid, out_data, out_id, out_last, busy
  );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_deframer_out_skid_buf.sv
// ============================================================================
// out_skid_buf : 2-entry register FIFO, output presented from the head entry
// Revision: 1.0
// ============================================================================
`default_nettype none

module out_skid_buf #(
  parameter int WIDTH = 37
) (
  input  logic             rclk_i,
  input  logic             rrst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pdata_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             w_pop;

  assign w_pop = (count_q != 2'd0) && ready_i;

  // Callers never push while full, so only the push+pop case needs a full-buffer path.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push_i, w_pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = pdata_i;
        else                 tail_d = pdata_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = pdata_i;
        end else begin
          head_d = tail_q;
          tail_d = pdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rclk_i or negedge rrst_i) begin
    if (!rrst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_deframer.sv
// ============================================================================
// fifo_rd_deframer : strips packet headers from the async FIFO read port and
//                    streams payload beats with ID and LAST
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_rd_deframer
  import fifo_deframer_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ID_SIZE   = 4,
  parameter int LEN_SIZE  = 8
) (
  input logic                rclk,
  input logic                rrst,
  fifo_rd_deframer_if.master bus
);

  localparam int ENTRY_W = DATA_SIZE + ID_SIZE + 1;

  state_e              state_q;
  logic [LEN_SIZE-1:0] remain_q;
  logic [ID_SIZE-1:0]  cur_id_q;

  logic [LEN_SIZE-1:0] w_hdr_len;
  logic [ID_SIZE-1:0]  w_hdr_id;
  logic [1:0]          w_count;
  logic                w_data_pop;
  logic [ENTRY_W-1:0]  w_head;
  logic [ENTRY_W-1:0]  w_pdata;

  assign w_hdr_len = LEN_SIZE'(hdr_len(64'(bus.rdata), LEN_SIZE));
  assign w_hdr_id  = ID_SIZE'(hdr_id(64'(bus.rdata), LEN_SIZE, ID_SIZE));

  // Pop gating only looks at registered occupancy, never at out_ready.
  assign w_data_pop = (state_q == DATA) && !bus.rempty && (w_count != 2'd2);
  assign bus.rpop   = rrst && !bus.rempty && ((state_q == HDR) || (w_count != 2'd2));

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      state_q  <= HDR;
      remain_q <= '0;
      cur_id_q <= '0;
    end else begin
      unique case (state_q)
        HDR: begin
          if (!bus.rempty) begin
            cur_id_q <= w_hdr_id;
            remain_q <= w_hdr_len;
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (w_data_pop) begin
            if (remain_q == '0) state_q <= HDR;
            else                remain_q <= remain_q - 1'b1;
          end
        end
        default: state_q <= HDR;
      endcase
    end
  end

  assign w_pdata = {bus.rdata, cur_id_q, (remain_q == '0)};

  out_skid_buf #(
    .WIDTH (ENTRY_W)
  ) u_skid (
    .rclk_i  (rclk),
    .rrst_i  (rrst),
    .push_i  (w_data_pop),
    .pdata_i (w_pdata),
    .valid_o (bus.out_valid),
    .ready_i (bus.out_ready),
    .data_o  (w_head),
    .count_o (w_count)
  );

  assign {bus.out_data, bus.out_id, bus.out_last} = w_head;
  assign bus.busy = (state_q == DATA) || (w_count != 2'd0);

endmodule

`default_nettype wire

// File: doc/fifo_rd_deframer.md
# fifo_rd_deframer

Read-side consumer of the crossbar's asynchronous FIFO, running entirely in the read clock domain. It drains header-framed packets from the FIFO's show-ahead read port (rempty/rdata/rpop), strips each header, and presents the payload beats on a valid/ready stream with per-beat ID and a LAST marker. Output goes through a registered 2-entry skid buffer, so that rpop never depends combinationally on out_ready.

## Interface
Parameters:
- DATA_SIZE, 32, FIFO word and payload width
- ID_SIZE, 4, packet ID width; header bits [LEN_SIZE+ID_SIZE-1:LEN_SIZE]
- LEN_SIZE, 8, beat-count field width; header bits [LEN_SIZE-1:0] carry (beats-1)
- Constraint: LEN_SIZE+ID_SIZE <= DATA_SIZE; unused header bits are ignored

Ports:
- rclk  input  1  read-domain clock; all state is on its rising edge
- rrst  input  1  asynchronous, active-low reset
- rempty  input  1  FIFO empty flag
- rdata  input  DATA_SIZE  FIFO head word; valid in the same cycle as !rempty
- rpop  output  1  pop FIFO head this cycle
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the beat
- out_data  output  DATA_SIZE  payload beat
- out_id  output  ID_SIZE  ID of the packet the beat belongs to
- out_last  output  1  final beat of the packet
- busy  output  1  high while in DATA state or the buffer is non-empty

## Operation
- State machine, two states:
  - HDR: waits for a header word.
    - If !rempty: pop it, latch cur_id = header ID and remain = header len, then go to DATA.
    - Header words never reach the output.
  - DATA: pop one payload word per cycle when !rempty and the buffer count < 2.
    - Each popped word is written to the buffer as {rdata, cur_id, remain==0}.
    - If remain==0 at the pop: return to HDR.
    - Otherwise: remain decrements.
- rpop:
  - HDR: rpop = !rempty.
  - DATA: rpop = !rempty && (count < 2).
  - count is the registered buffer occupancy, 0..2.
  - rpop is never asserted while rempty=1.
- Skid buffer:
  - A 2-entry FIFO; output taken from the head entry.
  - Push (pop from the source FIFO in DATA) and output transfer (out_valid && out_ready) may occur in the same cycle. count is then unchanged.
- Arithmetic: remain is LEN_SIZE bits and never wraps; a packet carries 1..2^LEN_SIZE beats.
- Reset (asynchronous assert, any point including mid-packet):
  - state=HDR, remain=0, cur_id=0, count=0.
  - out_valid=0, out_data=0, out_id=0, out_last=0, busy=0.
  - rpop=0 while rrst is low.
  - Any partially consumed packet is discarded. The FIFO read side must be reset on the same rrst.

## Timing
- Header pop: 1 cycle. Produces no output beat (one-cycle bubble per packet).
- Latency: a payload word popped in cycle N is on out_* in cycle N+1 if the buffer was empty.
- Throughput: with out_ready held high and the FIFO non-empty, one payload beat per cycle. A packet of B beats occupies B+1 cycles.
- Handshake:
  - out_data/out_id/out_last stay stable while out_valid && !out_ready.
  - out_valid does not drop without a transfer.
- rempty mid-packet: stay in DATA, no pop, no output change except draining already-buffered beats.
- Stall: out_ready low holds two beats in the buffer. rpop deasserts from the cycle after count reaches 2.
- len=0: the header is followed by exactly one beat with out_last=1, then HDR.

## Structure
- Package fifo_deframer_pkg:
  - state enum {HDR, DATA}
  - header field offset constants
  - the functions hdr_len() and hdr_id()
- Sub-module out_skid_buf:
  - Parameterised 2-entry register FIFO of width DATA_SIZE+ID_SIZE+1.
  - Ports: push/pdata, valid/ready/data, count.
  - Instantiated once.

## Test plan
- Reset, then header {id=3, len=2} followed by words A1, A2, A3 with out_ready=1.
  - Required: three beats on consecutive cycles, id=3.
  - out_last=1 only on A3.
  - rpop asserted 4 times in total.
- Header with len=0 and id=5, then word 0xDEAD_BEEF.
  - Required: one beat, out_last=1.
  - The next header is popped in the cycle after the data pop.
- 4-beat packet with out_ready=0 for 5 cycles.
  - Required: count reaches 2 and rpop stays low.
  - out_data holds the first beat, stable.
  - Release out_ready: all 4 beats delivered in order.
- FIFO empties after beat 2 of 4 for 3 cycles.
  - Required: rpop=0 while rempty=1.
  - Remaining beats resume with correct id; out_last is on beat 4.
- rrst pulled low mid-packet (after beat 1 of 4).
  - Required: out_valid=0 and rpop=0 immediately.
  - After release, the next word is treated as a header.
- Back-to-back headers with len=255, ID_SIZE=4.
  - Required: 256 beats per packet, no counter wrap.
  - out_last is on beat 256 only.
